scaled_adder_pipe: RTL and testbench

SCALED_ADDER_PIPE -- requirements
Module: scaled_adder_pipe

---
 rtl/adder_pkg.sv | 16 +
 rtl/scaled_sum.sv | 28 ++
 rtl/scaled_adder_pipe.sv | 136 +++++++++++++
 tb/tb_scaled_adder_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the scaled adder pipeline.
package adder_pkg;

  typedef enum logic [1:0] {
    ModeAdd    = 2'd0,
    ModeScale  = 2'd1,
    ModeAcc    = 2'd2,
    ModeAccClr = 2'd3
  } mode_e;

  // Operand-A values for which SCALE doubles a.
  localparam int unsigned ScaleA0 = 1;
  localparam int unsigned ScaleA1 = 2;
  localparam int unsigned ScaleA2 = 3;

endpackage

// File: rtl/scaled_sum.sv
// Combinational raw-sum: a+b, or 2*a+b for SCALE when a is in the scale set.
// The result is zero-extended to ACC_W, which must be at least W+2 so nothing is truncated.
module scaled_sum import adder_pkg::*; #(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 8
) (
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  mode_e            mode_i,
  output logic [ACC_W-1:0] raw_o
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic             scale_hit;

  // Widen first so the doubled operand keeps its carry bits.
  always_comb begin
    a_ext     = ACC_W'(a_i);
    b_ext     = ACC_W'(b_i);
    scale_hit = (a_i == W'(ScaleA0)) || (a_i == W'(ScaleA1)) || (a_i == W'(ScaleA2));
    raw_o     = a_ext + b_ext;
    if ((mode_i == ModeScale) && scale_hit) begin
      raw_o = (a_ext << 1) + b_ext;
    end
  end

endmodule

// File: rtl/scaled_adder_pipe.sv
// Two-stage valid/ready pipeline: S1 holds operands, S2 holds the (optionally gated) result.
// A saturating accumulator is updated as each beat moves from S1 to S2.
module scaled_adder_pipe import adder_pkg::*; #(
  parameter int unsigned W       = 4,
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned GATE_EN = 1,
  parameter int unsigned GATE_V0 = 3,
  parameter int unsigned GATE_V1 = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] c,
  output logic             sat
);

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  logic             s2_load;
  logic             s1_adv;
  logic             in_xfer;
  logic             gate_pass;
  logic [ACC_W-1:0] raw;
  logic [ACC_W-1:0] result;
  logic [ACC_W:0]   acc_sum;

  scaled_sum #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_scaled_sum (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .mode_i (s1_mode_q),
    .raw_o  (raw)
  );

  // Handshake: in_ready depends on out_ready only, never on in_valid.
  always_comb begin
    s2_load   = !s2_valid_q || out_ready;
    s1_adv    = s1_valid_q && s2_load;
    in_ready  = !s1_valid_q || s1_adv;
    in_xfer   = in_valid && in_ready;
    // No output transfer may complete while reset is being applied.
    out_valid = s2_valid_q && !rst;
    c         = c_q;
    sat       = sat_q;
  end

  // Result, accumulator and gating; acc/sat commit only when a beat leaves S1.
  always_comb begin
    acc_sum   = {1'b0, acc_q} + {1'b0, raw};
    acc_d     = acc_q;
    sat_d     = sat_q;
    result    = raw;
    gate_pass = (GATE_EN == 0) || (s1_b_q == W'(GATE_V0)) || (s1_b_q == W'(GATE_V1));
    case (s1_mode_q)
      ModeAcc: begin
        result = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        if (s1_adv) begin
          acc_d = result;
          if (acc_sum[ACC_W]) begin
            sat_d = 1'b1;
          end
        end
      end
      ModeAccClr: begin
        if (s1_adv) begin
          acc_d = raw;
          sat_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Stage-valid and data next-state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_mode_d  = mode_e'(mode);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        c_d = gate_pass ? result : '0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= ModeAdd;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_scaled_adder_pipe.sv
// Self-checking bench for scaled_adder_pipe (W=4, ACC_W=8, gate values 3/5).
module tb_scaled_adder_pipe;

  localparam int W      = 4;
  localparam int ACC_W  = 8;
  localparam int AccMax = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [1:0]       mode = 2'd0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] c;
  logic             sat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int c;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc = 0;
  int   m_sat = 0;
  bit   prev_stall = 1'b0;
  int   prev_c = 0;
  exp_t mon_e;
  int   mon_raw;
  int   mon_res;
  int   acc_cnt;
  bit   fired;

  scaled_adder_pipe #(
    .W       (W),
    .ACC_W   (ACC_W),
    .GATE_EN (1),
    .GATE_V0 (3),
    .GATE_V1 (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference raw sum straight from the arithmetic rules.
  function automatic int ref_raw(input int m, input int av, input int bv);
    if (m == 1 && av >= 1 && av <= 3) return 2 * av + bv;
    return av + bv;
  endfunction

  // Scoreboard: model each accepted beat, compare each delivered beat, watch stalls.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc      = 0;
      m_sat      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("stall_valid", 32'(out_valid), 32'd1);
        check_val("stall_c", 32'(c), prev_c);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("out_c", 32'(c), mon_e.c);
          check_val("out_sat", 32'(sat), mon_e.sat);
        end
      end
      if (in_valid && in_ready) begin
        mon_raw = ref_raw(int'(mode), int'(a), int'(b));
        mon_res = mon_raw;
        if (mode == 2'd2) begin
          if (m_acc + mon_raw > AccMax) begin
            m_acc = AccMax;
            m_sat = 1;
          end else begin
            m_acc = m_acc + mon_raw;
          end
          mon_res = m_acc;
        end else if (mode == 2'd3) begin
          m_acc = mon_raw;
          m_sat = 0;
        end
        mon_e.c   = (b == 4'd3 || b == 4'd5) ? mon_res : 0;
        mon_e.sat = m_sat;
        exp_q.push_back(mon_e);
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = int'(c);
    end
  end

  // Offer one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard = 0;
    mode     = m;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send with out_ready=1 and check the beat as it lands in S2 one cycle later.
  task automatic send_chk(input string tag, input logic [1:0] m, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int expc, input int exps);
    send(m, av, bv);
    @(posedge clk);
    #1;
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_c"}, 32'(c), expc);
    check_val({tag, "_sat"}, 32'(sat), exps);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_c", 32'(c), 32'd0);
    check_val("rst_sat", 32'(sat), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD, with first-beat latency: not visible one cycle after accept, visible after two.
    send(2'd0, 4'd4, 4'd3);
    check_val("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_val("lat_valid", 32'(out_valid), 32'd1);
    check_val("lat_c", 32'(c), 32'd7);
    send_chk("add_gated", 2'd0, 4'd4, 4'd4, 0, 0);

    send_chk("scale_2_5", 2'd1, 4'd2, 4'd5, 9, 0);
    send_chk("scale_15_3", 2'd1, 4'd15, 4'd3, 18, 0);
    send_chk("scale_3_3", 2'd1, 4'd3, 4'd3, 9, 0);

    // Accumulate to saturation: 3, 33, 63, ..., 243, then clamp at 255.
    send_chk("accclr_1_2", 2'd3, 4'd1, 4'd2, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      send_chk("acc_sat", 2'd2, 4'd15, 4'd15, 0, (i == 9) ? 1 : 0);
    end
    send_chk("acc_clamped", 2'd2, 4'd0, 4'd3, 255, 1);
    send_chk("accclr_0_3", 2'd3, 4'd0, 4'd3, 3, 0);
    drain();

    // Backpressure: with out_ready low only two beats fit.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'd0;
    a         = 4'd1;
    b         = 4'd3;
    acc_cnt   = 0;
    repeat (4) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      if (fired) begin
        acc_cnt++;
        a = a + 4'd1;
      end
    end
    check_val("bp_accepts", acc_cnt, 32'd2);
    check_val("bp_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Reset with both stages full and acc=100.
    send(2'd3, 4'd15, 4'd15);
    send(2'd2, 4'd15, 4'd15);
    send(2'd2, 4'd15, 4'd15);
    send(2'd2, 4'd5, 4'd5);
    drain();
    out_ready = 1'b0;
    send(2'd0, 4'd1, 4'd3);
    send(2'd0, 4'd2, 4'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_sat", 32'(sat), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send_chk("post_rst_acc", 2'd2, 4'd1, 4'd3, 4, 0);
    drain();

    // Randomized traffic with occasional resets.
    repeat (600) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom);
      a         = 4'($urandom);
      if ($urandom_range(0, 1) == 1) b = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'd5;
      else b = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
